vga_fb_writer: RTL and testbench
================================

Name: vga_fb_writer

Overview:
- Write-side port into the 1-bpp framebuffer in SRAM that the VGA scan-out block reads.
- Accepts single-pixel commands (clear, set, invert, read) addressed by (x, y).
- Performs a read-modify-write on the 32-bit SRAM word that holds the pixel, and honours SRAM_busy.
- Sits between the CPU/graphics request logic and the SRAM arbiter.

Parameters:
H_RES, 128, framebuffer width in pixels (multiple of 32)
V_RES, 96, framebuffer height in pixels
BASE_ADDR, 0, word address of pixel (0,0)
FILL_WORD, 32'h0000_0000, pattern written by the clear command

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
pix_valid  in  1  pixel command request
pix_ready  out  1  high in IDLE; command accepted when pix_valid & pix_ready at posedge
pix_x  in  10  pixel column
pix_y  in  9  pixel row
pix_op  in  2  00 clear bit, 01 set bit, 10 invert bit, 11 read bit
pix_done  out  1  one-cycle completion pulse
pix_err  out  1  valid with pix_done; coordinate out of range
pix_rdata  out  1  valid with pix_done; pixel value before modification
clr_req  in  1  start full-framebuffer clear
clr_busy  out  1  clear in progress
word_address_dest  out  32  SRAM word address
byte_select  out  4  SRAM byte enables
SRAM_data_out  out  32  SRAM write data
read_en  out  1  SRAM read request
write_en  out  1  SRAM write request
SRAM_data_in  in  32  SRAM read data
SRAM_busy  in  1  SRAM cannot accept a request this cycle

Behaviour:
- Reset: all outputs 0 except pix_ready=1. State=IDLE. Reset asserted mid-operation aborts it immediately; there is no partial write after release.
- Addressing: index = pix_y*H_RES + pix_x.
  - word = BASE_ADDR + (index >> 5); bit = 31 - index[4:0] (MSB is the leftmost pixel).
  - Arithmetic is at least 20 bits wide, zero-extended to 32.
- SRAM handshake:
  - A request (read_en or write_en) is accepted at a posedge where it is high and SRAM_busy=0.
  - Until acceptance, the request, word_address_dest, byte_select and SRAM_data_out are held stable.
  - Read data is valid on SRAM_data_in in the cycle after acceptance.
  - read_en and write_en are never high together.
- Byte enables: byte_select=4'b1111 during reads. During writes it is one-hot on the byte holding the bit (bit[4:3]: 3->1000, 2->0100, 1->0010, 0->0001).
- States:
  - IDLE: on accept, latch the command. In range -> RD_REQ. Out of range (x>=H_RES or y>=V_RES) -> RESP with pix_err=1, no SRAM traffic.
  - RD_REQ: read_en=1 until accepted -> RD_WAIT.
  - RD_WAIT: capture SRAM_data_in and set pix_rdata = captured bit. op 11 -> RESP; otherwise -> WR_REQ.
  - WR_REQ: SRAM_data_out = captured word with the bit modified; write_en=1 until accepted -> RESP.
  - RESP: pix_done=1 for one cycle -> IDLE.
  - CLEAR: see Optional Feature.
- pix_ready=1 only in IDLE.
- Minimum latency with SRAM_busy=0:
  - Write ops: pix_done 4 cycles after the accept edge.
  - op 11: 3 cycles.
  - Out of range: 1 cycle.
  - Each busy cycle adds one cycle.
- Simultaneous clr_req and pix_valid in IDLE: the clear wins and pix_ready=0 that cycle.
- clr_req outside IDLE is ignored; it is not queued.

Optional Feature:
- Macro: FB_CLEAR_EN.
- Defined:
  - clr_req in IDLE -> CLEAR state; clr_busy=1.
  - Words BASE_ADDR .. BASE_ADDR + H_RES*V_RES/32 - 1 are written in ascending order with FILL_WORD and byte_select=1111.
  - One write per accepted cycle; the address advances only on acceptance.
  - After the last write is accepted -> IDLE; clr_busy falls in the same cycle pix_ready rises.
- Undefined: clr_req is ignored, clr_busy is tied to 0, and the CLEAR state is absent.

Test Plan:
- Set pixel, x=33 y=0, SRAM word 1 = 0, busy=0 -> read addr 1 with be 1111; write addr 1 with data 0x4000_0000 and be 1000; pix_done 4 cycles after accept; pix_rdata=0; pix_err=0.
- Invert pixel, x=127 y=95, word 383 = 0xFCA8_6420 -> write addr 383 with data 0xFCA8_6421 and be 0001; pix_rdata=0.
- Read op 11 at x=1 y=0 on word 0 = 0x4000_0000 -> no write_en; pix_done at cycle 3; pix_rdata=1.
- x=128 y=5 -> pix_done next cycle with pix_err=1; read_en and write_en stay 0.
- SRAM_busy high 5 cycles during RD_REQ -> read_en and address held stable; pix_done at cycle 9.
- FB_CLEAR_EN, FILL_WORD=0 -> 384 writes to addresses 0..383 with busy=0; clr_busy high exactly 384 cycles; pix_valid not accepted meanwhile. nrst pulsed mid-clear -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/vga_fb_writer_if.sv
// vga_fb_writer_if: pixel command port plus SRAM arbiter port of vga_fb_writer.
interface vga_fb_writer_if;
   logic        pix_valid;
   logic        pix_ready;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic [1:0]  pix_op;
   logic        pix_done;
   logic        pix_err;
   logic        pix_rdata;
   logic        clr_req;
   logic        clr_busy;
   logic [31:0] word_address_dest;
   logic [3:0]  byte_select;
   logic [31:0] SRAM_data_out;
   logic        read_en;
   logic        write_en;
   logic [31:0] SRAM_data_in;
   logic        SRAM_busy;
   modport master (
      output pix_valid, pix_x, pix_y, pix_op, clr_req, SRAM_data_in, SRAM_busy,
      input  pix_ready, pix_done, pix_err, pix_rdata, clr_busy,
             word_address_dest, byte_select, SRAM_data_out, read_en, write_en
   );
   modport slave (
      input  pix_valid, pix_x, pix_y, pix_op, clr_req, SRAM_data_in, SRAM_busy,
      output pix_ready, pix_done, pix_err, pix_rdata, clr_busy,
             word_address_dest, byte_select, SRAM_data_out, read_en, write_en
   );
endinterface

// File: rtl/vga_fb_writer.sv
// vga_fb_writer: single-pixel read-modify-write port into the 1-bpp VGA framebuffer SRAM.
// Define FB_CLEAR_EN to build in the full-framebuffer clear driven by clr_req.
module vga_fb_writer #(
   parameter int unsigned H_RES     = 128,
   parameter int unsigned V_RES     = 96,
   parameter int unsigned BASE_ADDR = 0,
   parameter logic [31:0] FILL_WORD = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           nrst,
   vga_fb_writer_if.slave bus
);
   localparam int unsigned LAST_ADDR = BASE_ADDR + H_RES * V_RES / 32 - 1;
   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP
`ifdef FB_CLEAR_EN
      , CLEAR
`endif
   } state_t;
   state_t      r_state;
   logic [1:0]  r_op;
   logic [4:0]  r_bit;
   logic [31:0] r_addr, r_wdata;
   logic [3:0]  r_be;
   logic        r_rd_en, r_wr_en, r_done, r_err, r_rdata;
   logic [31:0] w_index, w_mask, w_wdata;
   logic        w_oor, w_clr;
   assign w_index = 32'(bus.pix_y) * H_RES + 32'(bus.pix_x);
   assign w_oor   = (32'(bus.pix_x) >= H_RES) || (32'(bus.pix_y) >= V_RES);
   assign w_mask  = 32'b1 << r_bit;
   assign w_wdata = r_op == 2'b00 ? bus.SRAM_data_in & ~w_mask :
                    r_op == 2'b01 ? bus.SRAM_data_in | w_mask : bus.SRAM_data_in ^ w_mask;
`ifdef FB_CLEAR_EN
   assign w_clr        = bus.clr_req;
   assign bus.clr_busy = r_state == CLEAR;
`else
   assign w_clr        = 1'b0;
   assign bus.clr_busy = 1'b0;
`endif
   // A clear request in IDLE takes priority, so the command port is closed that cycle.
   assign bus.pix_ready         = (r_state == IDLE) && !w_clr;
   assign bus.pix_done          = r_done;
   assign bus.pix_err           = r_err;
   assign bus.pix_rdata         = r_rdata;
   assign bus.word_address_dest = r_addr;
   assign bus.byte_select       = r_be;
   assign bus.SRAM_data_out     = r_wdata;
   assign bus.read_en           = r_rd_en;
   assign bus.write_en          = r_wr_en;
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= IDLE;
         r_op    <= 2'b00;
         r_bit   <= 5'd0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_be    <= 4'd0;
         r_rd_en <= 1'b0;
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
`ifdef FB_CLEAR_EN
               if (bus.clr_req) begin
                  r_state <= CLEAR;
                  r_wr_en <= 1'b1;
                  r_addr  <= BASE_ADDR;
                  r_be    <= 4'b1111;
                  r_wdata <= FILL_WORD;
               end else
`endif
               if (bus.pix_valid) begin
                  r_op    <= bus.pix_op;
                  r_bit   <= ~w_index[4:0];
                  r_addr  <= BASE_ADDR + (w_index >> 5);
                  r_be    <= 4'b1111;
                  r_err   <= w_oor;
                  r_rdata <= 1'b0;
                  r_rd_en <= !w_oor;
                  r_state <= w_oor ? RESP : RD_REQ;
               end
            end
            RD_REQ:
               if (!bus.SRAM_busy) begin
                  r_rd_en <= 1'b0;
                  r_state <= RD_WAIT;
               end
            RD_WAIT: begin
               r_rdata <= bus.SRAM_data_in[r_bit];
               r_wdata <= w_wdata;
               r_be    <= 4'b0001 << r_bit[4:3];
               r_wr_en <= r_op != 2'b11;
               r_state <= r_op == 2'b11 ? RESP : WR_REQ;
            end
            WR_REQ:
               if (!bus.SRAM_busy) begin
                  r_wr_en <= 1'b0;
                  r_state <= RESP;
               end
            RESP: begin
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
`ifdef FB_CLEAR_EN
            CLEAR:
               if (!bus.SRAM_busy) begin
                  if (r_addr == LAST_ADDR) begin
                     r_wr_en <= 1'b0;
                     r_state <= IDLE;
                  end else r_addr <= r_addr + 32'd1;
               end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vga_fb_writer.sv
// tb_vga_fb_writer: randomized and directed checks of vga_fb_writer against a pixel-level SRAM model.
module tb_vga_fb_writer;
   logic clk = 1'b0;
   logic nrst = 1'b0;
   vga_fb_writer_if bus ();
   vga_fb_writer dut (.clk(clk), .nrst(nrst), .bus(bus));
   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   logic [31:0] mem [384];
   int n_rd = 0, n_wr = 0, clr_next = 0;
   logic [31:0] last_ra, last_wa, last_wd;
   logic [3:0]  last_rbe, last_wbe;
   int cyc = 0, force_until = 0;
   bit rnd_en = 0;
   bit pend = 0;
   logic [33:0] snap_a;
   logic [35:0] snap_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // SRAM model: accepts requests when not busy, returns read data the next cycle.
   always @(posedge clk) begin
      if (!nrst) begin
         pend = 0;
         bus.SRAM_data_in <= '0;
      end else begin
         if (bus.read_en || bus.write_en) chk("rd_wr_excl", {31'd0, bus.read_en & bus.write_en}, 0);
         if (pend) begin
            chk("hold_req_addr", {bus.read_en, bus.write_en, bus.word_address_dest[29:0]}, snap_a[31:0]);
            chk("hold_data", bus.SRAM_data_out, snap_b[31:0]);
            chk("hold_be", {28'd0, bus.byte_select}, {28'd0, snap_b[35:32]});
         end
         pend = (bus.read_en || bus.write_en) && bus.SRAM_busy;
         snap_a = {2'b00, bus.read_en, bus.write_en, bus.word_address_dest[29:0]};
         snap_b = {bus.byte_select, bus.SRAM_data_out};
         if (bus.read_en && !bus.SRAM_busy) begin
            n_rd++;
            last_ra = bus.word_address_dest;
            last_rbe = bus.byte_select;
            bus.SRAM_data_in <= bus.word_address_dest < 384 ? mem[bus.word_address_dest] : 32'hDEAD_BEEF;
         end
         if (bus.write_en && !bus.SRAM_busy) begin
            n_wr++;
            last_wa = bus.word_address_dest;
            last_wbe = bus.byte_select;
            last_wd = bus.SRAM_data_out;
            if (bus.clr_busy) begin
               chk("clr_addr", bus.word_address_dest, clr_next);
               chk("clr_be", {28'd0, bus.byte_select}, 32'hF);
               chk("clr_data", bus.SRAM_data_out, 32'h0);
               clr_next++;
            end
            if (bus.word_address_dest < 384)
               for (int b = 0; b < 4; b++)
                  if (bus.byte_select[b]) mem[bus.word_address_dest][8*b +: 8] = bus.SRAM_data_out[8*b +: 8];
         end
      end
   end

   always @(negedge clk) begin
      bus.SRAM_busy = (cyc < force_until) ? 1'b1 : (rnd_en ? 1'($urandom % 2) : 1'b0);
      cyc++;
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_ready"}, {31'd0, bus.pix_ready}, 1);
      chk({tag, "_outs"}, {26'd0, bus.pix_done, bus.pix_err, bus.pix_rdata, bus.clr_busy, bus.read_en, bus.write_en}, 0);
      chk({tag, "_addr"}, bus.word_address_dest, 0);
      chk({tag, "_data"}, bus.SRAM_data_out, 0);
      chk({tag, "_be"}, {28'd0, bus.byte_select}, 0);
   endtask

   // One pixel command; the model predicts the pixel, SRAM traffic and resulting word.
   task automatic pix_cmd(input int x, input int y, input int op, input int exp_lat, input int busy_n, input bit clr_mid);
      int idx, wa, bp, lat, w0, r0;
      bit oor, old_bit;
      logic [31:0] exp_word;
      oor = (x >= 128) || (y >= 96);
      idx = y * 128 + x;
      wa = idx / 32;
      bp = 31 - idx % 32;
      old_bit = 0;
      exp_word = 0;
      if (!oor) begin
         exp_word = mem[wa];
         old_bit = exp_word[bp];
         if (op == 0) exp_word[bp] = 1'b0;
         else if (op == 1) exp_word[bp] = 1'b1;
         else if (op == 2) exp_word[bp] = ~old_bit;
      end
      w0 = n_wr;
      r0 = n_rd;
      @(negedge clk);
      chk("pix_ready", {31'd0, bus.pix_ready}, 1);
      bus.pix_valid = 1;
      bus.pix_x = 10'(x);
      bus.pix_y = 9'(y);
      bus.pix_op = 2'(op);
      @(posedge clk);
      #1;
      bus.pix_valid = 0;
      force_until = cyc + busy_n;
      if (clr_mid) bus.clr_req = 1;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.pix_done && lat < 200);
      bus.clr_req = 0;
      chk("pix_done", {31'd0, bus.pix_done}, 1);
      if (exp_lat > 0) chk("latency", lat, exp_lat);
      chk("pix_err", {31'd0, bus.pix_err}, {31'd0, oor});
      chk("pix_rdata", {31'd0, bus.pix_rdata}, {31'd0, old_bit});
      chk("clr_busy_idle", {31'd0, bus.clr_busy}, 0);
      if (oor) chk("oor_no_traffic", n_rd + n_wr, r0 + w0);
      else begin
         chk("rd_count", n_rd, r0 + 1);
         chk("rd_addr", last_ra, wa);
         chk("rd_be", {28'd0, last_rbe}, 32'hF);
         chk("mem_word", mem[wa], exp_word);
         if (op == 3) chk("no_write", n_wr, w0);
         else begin
            chk("wr_count", n_wr, w0 + 1);
            chk("wr_addr", last_wa, wa);
            chk("wr_be", {28'd0, last_wbe}, 32'd1 << (bp / 8));
            chk("wr_data", last_wd, exp_word);
         end
      end
      @(posedge clk);
      #1;
      chk("done_pulse", {31'd0, bus.pix_done}, 0);
   endtask

   initial begin
      int w0, r0, cnt, rdy_hi, nz;
      bus.pix_valid = 0; bus.pix_x = 0; bus.pix_y = 0; bus.pix_op = 0; bus.clr_req = 0;
      for (int i = 0; i < 384; i++) mem[i] = $urandom;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      nrst = 1;
      mem[1] = 32'h0;
      pix_cmd(33, 0, 1, 4, 0, 0);
      mem[383] = 32'hFCA8_6420;
      pix_cmd(127, 95, 2, 4, 0, 0);
      mem[0] = 32'h4000_0000;
      pix_cmd(1, 0, 3, 3, 0, 0);
      pix_cmd(128, 5, 0, 1, 0, 0);
      pix_cmd(7, 96, 1, 1, 0, 0);
      pix_cmd(40, 20, 1, 9, 5, 0);
      pix_cmd(0, 0, 0, 4, 0, 1);
      rnd_en = 1;
      for (int k = 0; k < 40; k++)
         pix_cmd($urandom_range(0, 140), $urandom_range(0, 100), $urandom_range(0, 3), 0, 0, k % 5 == 0);
      rnd_en = 0;
      // Abort mid-operation: nothing may be written after release.
      @(negedge clk);
      bus.pix_valid = 1; bus.pix_x = 5; bus.pix_y = 3; bus.pix_op = 1;
      @(posedge clk);
      #1;
      bus.pix_valid = 0;
      force_until = cyc + 20;
      repeat (3) @(posedge clk);
      @(negedge clk);
      nrst = 0;
      #1;
      chk_reset("rst_mid_op");
      @(negedge clk);
      nrst = 1;
      w0 = n_wr;
      repeat (25) @(posedge clk);
      #1;
      chk("rst_no_write", n_wr, w0);
      chk("rst_no_read", {31'd0, bus.read_en}, 0);
`ifdef FB_CLEAR_EN
      w0 = n_wr;
      r0 = n_rd;
      clr_next = 0;
      @(negedge clk);
      bus.clr_req = 1;
      bus.pix_valid = 1; bus.pix_x = 2; bus.pix_y = 2; bus.pix_op = 1;
      #1;
      chk("clr_wins_ready", {31'd0, bus.pix_ready}, 0);
      @(posedge clk);
      #1;
      bus.clr_req = 0;
      cnt = 0;
      rdy_hi = 0;
      while (bus.clr_busy && cnt < 1000) begin
         cnt++;
         if (bus.pix_ready) rdy_hi++;
         @(posedge clk);
         #1;
      end
      bus.pix_valid = 0;
      chk("clr_busy_cycles", cnt, 384);
      chk("clr_ready_low", rdy_hi, 0);
      chk("clr_ready_back", {31'd0, bus.pix_ready}, 1);
      chk("clr_writes", n_wr - w0, 384);
      chk("clr_last", clr_next, 384);
      nz = 0;
      for (int i = 0; i < 384; i++) if (mem[i] !== 32'h0) nz++;
      chk("clr_mem_zero", nz, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("clr_pix_not_taken", n_rd, r0);
      pix_cmd(2, 2, 1, 4, 0, 0);
      for (int i = 0; i < 384; i++) mem[i] = $urandom;
      @(negedge clk);
      bus.clr_req = 1;
      @(posedge clk);
      #1;
      bus.clr_req = 0;
      repeat (50) @(posedge clk);
      @(negedge clk);
      chk("clr2_busy", {31'd0, bus.clr_busy}, 1);
      nrst = 0;
      #1;
      chk_reset("rst_mid_clr");
      @(negedge clk);
      nrst = 1;
      w0 = n_wr;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_clr_no_write", n_wr, w0);
      chk("rst_clr_busy", {31'd0, bus.clr_busy}, 0);
`else
      bus.clr_req = 1;
      pix_cmd(4, 4, 1, 4, 0, 1);
      @(negedge clk);
      bus.clr_req = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("clr_ignored", {31'd0, bus.clr_busy}, 0);
      chk("clr_no_write", {31'd0, bus.write_en}, 0);
      bus.clr_req = 0;
`endif
      pix_cmd(64, 48, 2, 4, 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end
endmodule
